// File: rtl/morse_transmitter.sv
// Morse keyer: turns one accepted ASCII character into dot/dash keying on
// morse_o, with the dot unit latched from dot_period_i at accept time.
//
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   char_i, char_valid_i         character offered with valid
//   char_ready_o                 high only while idle
//   dot_period_i                 dot unit in clock cycles, sampled on accept
//   morse_o                      keying output, 1 = mark
//   busy_o                       character or gap in progress
//   unknown_o                    pulse: accepted character has no code
//   dot_period_error_o           pulse: accepted with zero dot period
module morse_transmitter #(
    parameter int DOT_PERIOD_WIDTH = 28,
    parameter int MAX_SYMBOLS      = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [7:0]                  char_i,
    input  logic                        char_valid_i,
    output logic                        char_ready_o,
    input  logic [DOT_PERIOD_WIDTH-1:0] dot_period_i,
    output logic                        morse_o,
    output logic                        busy_o,
    output logic                        unknown_o,
    output logic                        dot_period_error_o
);

    // Two extra bits so 4U fits at the largest dot period.
    localparam int CW = DOT_PERIOD_WIDTH + 2;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        SYM_GAP,
        CHAR_GAP,
        WORD_GAP
    } state_t;

    state_t                      state_q;
    logic [CW-1:0]               cnt_q;
    logic [DOT_PERIOD_WIDTH-1:0] unit_q;
    logic [MAX_SYMBOLS-1:0]      pat_q;
    logic [2:0]                  len_q;
    logic [2:0]                  idx_q;
    logic                        morse_q;
    logic                        busy_q;
    logic                        ready_q;
    logic                        unknown_q;
    logic                        err_q;

    // Code table lookup: entry = {length[2:0], pattern[4:0]},
    // pattern right-aligned, first symbol in bit length-1, 1 = dash.
    logic [7:0]             ch_up;
    logic [7:0]             entry;
    logic [2:0]             code_len;
    logic [MAX_SYMBOLS-1:0] code_pat;
    logic [MAX_SYMBOLS-1:0] pat_aligned;
    logic                   is_space;

    always_comb begin
        ch_up = char_i;
        if (char_i >= 8'h61 && char_i <= 8'h7A) begin
            ch_up = char_i - 8'd32;
        end
        unique case (ch_up)
            8'h41: entry = {3'd2, 5'b00001};
            8'h42: entry = {3'd4, 5'b01000};
            8'h43: entry = {3'd4, 5'b01010};
            8'h44: entry = {3'd3, 5'b00100};
            8'h45: entry = {3'd1, 5'b00000};
            8'h46: entry = {3'd4, 5'b00010};
            8'h47: entry = {3'd3, 5'b00110};
            8'h48: entry = {3'd4, 5'b00000};
            8'h49: entry = {3'd2, 5'b00000};
            8'h4A: entry = {3'd4, 5'b00111};
            8'h4B: entry = {3'd3, 5'b00101};
            8'h4C: entry = {3'd4, 5'b00100};
            8'h4D: entry = {3'd2, 5'b00011};
            8'h4E: entry = {3'd2, 5'b00010};
            8'h4F: entry = {3'd3, 5'b00111};
            8'h50: entry = {3'd4, 5'b00110};
            8'h51: entry = {3'd4, 5'b01101};
            8'h52: entry = {3'd3, 5'b00010};
            8'h53: entry = {3'd3, 5'b00000};
            8'h54: entry = {3'd1, 5'b00001};
            8'h55: entry = {3'd3, 5'b00001};
            8'h56: entry = {3'd4, 5'b00001};
            8'h57: entry = {3'd3, 5'b00011};
            8'h58: entry = {3'd4, 5'b01001};
            8'h59: entry = {3'd4, 5'b01011};
            8'h5A: entry = {3'd4, 5'b01100};
            8'h30: entry = {3'd5, 5'b11111};
            8'h31: entry = {3'd5, 5'b01111};
            8'h32: entry = {3'd5, 5'b00111};
            8'h33: entry = {3'd5, 5'b00011};
            8'h34: entry = {3'd5, 5'b00001};
            8'h35: entry = {3'd5, 5'b00000};
            8'h36: entry = {3'd5, 5'b10000};
            8'h37: entry = {3'd5, 5'b11000};
            8'h38: entry = {3'd5, 5'b11100};
            8'h39: entry = {3'd5, 5'b11110};
            default: entry = 8'h00;
        endcase
        code_len    = entry[7:5];
        code_pat    = entry[MAX_SYMBOLS-1:0];
        // Left-align so the next symbol is always the MSB.
        pat_aligned = code_pat << (3'(MAX_SYMBOLS) - code_len);
        is_space    = (char_i == 8'h20);
    end

    // Durations for the incoming and the latched unit.
    logic [CW-1:0] in_u;
    logic [CW-1:0] in_3u;
    logic [CW-1:0] in_4u;
    logic [CW-1:0] lat_u;
    logic [CW-1:0] lat_3u;

    assign in_u   = CW'(dot_period_i);
    assign in_3u  = in_u + (in_u << 1);
    assign in_4u  = in_u << 2;
    assign lat_u  = CW'(unit_q);
    assign lat_3u = lat_u + (lat_u << 1);

    logic last_sym;
    assign last_sym = (idx_q == len_q - 3'd1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            unit_q    <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            morse_q   <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            unknown_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            unknown_q <= 1'b0;
            err_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (char_valid_i) begin
                        unit_q <= dot_period_i;
                        // Zero period outranks an unknown code.
                        if (dot_period_i == '0) begin
                            err_q <= 1'b1;
                        end else if (is_space) begin
                            state_q <= WORD_GAP;
                            cnt_q   <= in_4u - CW'(1);
                            busy_q  <= 1'b1;
                            ready_q <= 1'b0;
                        end else if (code_len == 3'd0) begin
                            unknown_q <= 1'b1;
                        end else begin
                            state_q <= MARK;
                            pat_q   <= pat_aligned;
                            len_q   <= code_len;
                            idx_q   <= '0;
                            morse_q <= 1'b1;
                            busy_q  <= 1'b1;
                            ready_q <= 1'b0;
                            cnt_q   <= (pat_aligned[MAX_SYMBOLS-1] ?
                                        in_3u : in_u) - CW'(1);
                        end
                    end
                end
                MARK: begin
                    if (cnt_q == '0) begin
                        morse_q <= 1'b0;
                        if (last_sym) begin
                            state_q <= CHAR_GAP;
                            cnt_q   <= lat_3u - CW'(1);
                        end else begin
                            state_q <= SYM_GAP;
                            cnt_q   <= lat_u - CW'(1);
                            idx_q   <= idx_q + 3'd1;
                            pat_q   <= pat_q << 1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                SYM_GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= MARK;
                        morse_q <= 1'b1;
                        cnt_q   <= (pat_q[MAX_SYMBOLS-1] ?
                                    lat_3u : lat_u) - CW'(1);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                CHAR_GAP, WORD_GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    morse_q <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign morse_o            = morse_q;
    assign busy_o             = busy_q;
    assign char_ready_o       = ready_q;
    assign unknown_o          = unknown_q;
    assign dot_period_error_o = err_q;

endmodule

// File: tb/tb_morse_transmitter.sv
// Bench for morse_transmitter: directed cases plus random traffic,
// scored cycle by cycle against a string-table Morse waveform model.
module tb_morse_transmitter;

    localparam int DPW = 28;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [7:0]     char_i;
    logic           char_valid_i;
    logic           char_ready_o;
    logic [DPW-1:0] dot_period_i;
    logic           morse_o;
    logic           busy_o;
    logic           unknown_o;
    logic           dot_period_error_o;

    morse_transmitter #(
        .DOT_PERIOD_WIDTH(DPW),
        .MAX_SYMBOLS     (5)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .char_i            (char_i),
        .char_valid_i      (char_valid_i),
        .char_ready_o      (char_ready_o),
        .dot_period_i      (dot_period_i),
        .morse_o           (morse_o),
        .busy_o            (busy_o),
        .unknown_o         (unknown_o),
        .dot_period_error_o(dot_period_error_o)
    );

    always #5 clk_i = ~clk_i;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference: Morse strings per character, expanded to a level queue.
    string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.",
        "--.", "....", "..", ".---", "-.-", ".-..", "--", "-.", "---",
        ".--.", "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
        "-.--", "--.."};
    string digits[10] = '{"-----", ".----", "..---", "...--", "....-",
        ".....", "-....", "--...", "---..", "----."};

    bit q[$];
    bit m_ready = 1'b1;
    bit m_busy  = 1'b0;
    bit m_morse = 1'b0;
    bit m_unk   = 1'b0;
    bit m_err   = 1'b0;
    bit acc     = 1'b0;

    function automatic string lookup(input logic [7:0] c);
        if (c >= 8'h61 && c <= 8'h7A) return letters[c - 8'h61];
        if (c >= 8'h41 && c <= 8'h5A) return letters[c - 8'h41];
        if (c >= 8'h30 && c <= 8'h39) return digits[c - 8'h30];
        return "";
    endfunction

    function automatic void push_run(input bit lvl, input int n);
        repeat (n) q.push_back(lvl);
    endfunction

    function automatic void model_edge();
        int    u;
        string s;
        acc   = 1'b0;
        m_unk = 1'b0;
        m_err = 1'b0;
        if (m_ready && char_valid_i) begin
            acc = 1'b1;
            u   = int'(dot_period_i);
            s   = lookup(char_i);
            if (u == 0) begin
                m_err = 1'b1;
            end else if (char_i == 8'h20) begin
                push_run(1'b0, 4 * u);
            end else if (s.len() == 0) begin
                m_unk = 1'b1;
            end else begin
                for (int i = 0; i < s.len(); i++) begin
                    push_run(1'b1, (s[i] == 8'h2D) ? 3 * u : u);
                    push_run(1'b0, (i == s.len() - 1) ? 3 * u : u);
                end
            end
        end
        if (q.size() != 0) begin
            m_morse = q.pop_front();
            m_busy  = 1'b1;
            m_ready = 1'b0;
        end else begin
            m_morse = 1'b0;
            m_busy  = 1'b0;
            m_ready = 1'b1;
        end
    endfunction

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        chk("morse", morse_o, m_morse);
        chk("busy", busy_o, m_busy);
        chk("ready", char_ready_o, m_ready);
        chk("unknown", unknown_o, m_unk);
        chk("dperr", dot_period_error_o, m_err);
    endtask

    task automatic send(input logic [7:0] c, input int u);
        int n = 0;
        char_i       = c;
        dot_period_i = DPW'(u);
        char_valid_i = 1'b1;
        do begin
            step();
            n++;
        end while (!acc && n < 400);
        chk("accept", acc, 1);
        char_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!m_ready && n < 1000) begin
            step();
            n++;
        end
        chk("idle", char_ready_o, 1);
    endtask

    task automatic send_str(input string s, input int u);
        for (int i = 0; i < s.len(); i++) send(s[i], u);
        wait_idle();
    endtask

    int busy_cnt;

    initial begin
        rst_i        = 1'b1;
        char_valid_i = 1'b0;
        char_i       = 8'h00;
        dot_period_i = '0;
        repeat (2) @(negedge clk_i);
        chk("rst_morse", morse_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", char_ready_o, 1);
        chk("rst_unk", unknown_o, 0);
        chk("rst_err", dot_period_error_o, 0);
        rst_i = 1'b0;

        // Single dot, then 'a'/'A' with a busy length count.
        send("E", 4);
        wait_idle();
        send("a", 2);
        busy_cnt = 1;
        while (busy_o && busy_cnt < 100) begin
            step();
            if (busy_o) busy_cnt++;
        end
        chk("busy_len_a", busy_cnt, 16);
        send("A", 2);
        wait_idle();

        // Words with a space.
        send_str("SOS SOS", 1);

        // Unknown, zero period, zero period on unknown.
        send("#", 3);
        send("T", 0);
        send("#", 0);
        send("z", 1);
        wait_idle();

        // Hold valid with changing data while busy.
        char_valid_i = 1'b1;
        char_i       = "K";
        dot_period_i = 2;
        step();
        for (int i = 0; i < 40; i++) begin
            char_i       = (i % 2) ? "M" : "0";
            dot_period_i = DPW'($urandom_range(1, 3));
            step();
        end
        char_valid_i = 1'b0;
        wait_idle();

        // Reset in the middle of a dash.
        send("T", 10);
        repeat (4) step();
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_morse", morse_o, 0);
        chk("arst_ready", char_ready_o, 1);
        chk("arst_busy", busy_o, 0);
        q.delete();
        m_ready = 1'b1;
        m_busy  = 1'b0;
        m_morse = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        send("E", 10);
        wait_idle();

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            int r;
            r            = $urandom_range(0, 9);
            char_valid_i = ($urandom_range(0, 3) != 0);
            if (r <= 3)      char_i = 8'($urandom_range(8'h41, 8'h5A));
            else if (r <= 5) char_i = 8'($urandom_range(8'h61, 8'h7A));
            else if (r == 6) char_i = 8'($urandom_range(8'h30, 8'h39));
            else if (r == 7) char_i = 8'h20;
            else if (r == 8) char_i = 8'h23;
            else             char_i = 8'($urandom_range(0, 255));
            dot_period_i = ($urandom_range(0, 15) == 0) ? '0 :
                           DPW'($urandom_range(1, 3));
            step();
        end
        char_valid_i = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
